// File: rtl/decision_seg_if.sv
// Handshake and data bundle between the search controller / state list and decision_seg.
// The master side is the controller; the slave side is the decision unit.
interface decision_seg_if #(
   parameter int NUM_VARS  = 32,
   parameter int WIDTH_IDX = 5,
   parameter int WIDTH_LVL = 16
);
   logic                    load_lvl_en;
   logic [WIDTH_LVL-1:0]    load_lvl_i;
   logic                    decision_req;
   logic [NUM_VARS*3-1:0]   vars_value_i;
   logic [NUM_VARS-1:0]     index_decided_o;
   logic [WIDTH_IDX-1:0]    var_idx_o;
   logic                    decision_done;
   logic                    all_assigned_o;
   logic                    busy_o;
   logic                    apply_bkt_i;
   logic [WIDTH_LVL-1:0]    bkt_lvl_i;
   logic [WIDTH_LVL-1:0]    cur_lvl_o;
   logic                    lvl_overflow_o;

   modport master (
      output load_lvl_en, load_lvl_i, decision_req, vars_value_i, apply_bkt_i, bkt_lvl_i,
      input  index_decided_o, var_idx_o, decision_done, all_assigned_o, busy_o,
             cur_lvl_o, lvl_overflow_o
   );

   modport slave (
      input  load_lvl_en, load_lvl_i, decision_req, vars_value_i, apply_bkt_i, bkt_lvl_i,
      output index_decided_o, var_idx_o, decision_done, all_assigned_o, busy_o,
             cur_lvl_o, lvl_overflow_o
   );
endinterface

// File: rtl/decision_seg.sv
// Segmented decider: scans SEG_VARS variables per cycle for the lowest-index free one
// and owns the decision-level counter (load / backtrack / increment with overflow guard).
module decision_seg #(
   parameter int NUM_VARS  = 32,
   parameter int SEG_VARS  = 8,
   parameter int WIDTH_IDX = 5,
   parameter int WIDTH_LVL = 16
) (
   input  logic          clk,
   input  logic          rst,
   decision_seg_if.slave bus
);
   localparam int NSEG      = NUM_VARS / SEG_VARS;
   localparam int WIDTH_SEG = (NSEG > 1) ? $clog2(NSEG) : 1;
   // All-ones means "no level", so the last legal increment target is all-ones minus one.
   localparam logic [WIDTH_LVL-1:0] LVL_LAST = {{(WIDTH_LVL-1){1'b1}}, 1'b0};

   typedef enum logic {IDLE, SCAN} state_e;

   state_e                state_q, state_d;
   logic [WIDTH_SEG-1:0]  seg_cnt_q, seg_cnt_d;
   logic [NUM_VARS-1:0]   onehot_q, onehot_d;
   logic [WIDTH_IDX-1:0]  var_idx_q, var_idx_d;
   logic                  done_q, done_d;
   logic                  all_q, all_d;
   logic [WIDTH_LVL-1:0]  next_lvl_q, next_lvl_d;
   logic                  ovf_q, ovf_d;

   logic [31:0]           seg_base;
   logic [SEG_VARS*3-1:0] seg_vals;
   logic [SEG_VARS-1:0]   seg_free;
   logic                  hit_found;
   logic [WIDTH_IDX-1:0]  hit_idx;
   logic                  abort;

   // Values are sampled live; upstream keeps them stable while busy.
   assign seg_base = 32'(seg_cnt_q) * 32'(SEG_VARS);
   assign seg_vals = bus.vars_value_i[seg_base*3 +: SEG_VARS*3];

   for (genvar j = 0; j < SEG_VARS; j++) begin : g_free
      assign seg_free[j] = (seg_vals[3*j +: 2] == 2'b00);
   end

   assign hit_found = |seg_free;
   assign abort     = bus.load_lvl_en | bus.apply_bkt_i;

   always_comb begin
      hit_idx = '0;
      for (int j = SEG_VARS-1; j >= 0; j--) begin
         if (seg_free[j]) hit_idx = WIDTH_IDX'(seg_base + 32'(j));
      end
   end

   always_comb begin
      state_d    = state_q;
      seg_cnt_d  = seg_cnt_q;
      onehot_d   = '0;
      var_idx_d  = var_idx_q;
      done_d     = 1'b0;
      all_d      = 1'b0;
      next_lvl_d = next_lvl_q;
      ovf_d      = ovf_q;

      if (bus.load_lvl_en) begin
         next_lvl_d = bus.load_lvl_i;
         ovf_d      = 1'b0;
      end else if (bus.apply_bkt_i) begin
         next_lvl_d = bus.bkt_lvl_i;
      end

      case (state_q)
         IDLE: begin
            if (bus.decision_req) begin
               state_d   = SCAN;
               seg_cnt_d = '0;
            end
         end
         SCAN: begin
            // A level change mid-scan cancels the scan even on a same-cycle hit.
            if (abort) begin
               state_d = IDLE;
            end else if (hit_found) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               var_idx_d = hit_idx;
               onehot_d  = {{(NUM_VARS-1){1'b0}}, 1'b1} << hit_idx;
               if (next_lvl_q == LVL_LAST) ovf_d = 1'b1;
               else                        next_lvl_d = next_lvl_q + 1'b1;
            end else if (seg_cnt_q == WIDTH_SEG'(NSEG-1)) begin
               state_d = IDLE;
               all_d   = 1'b1;
            end else begin
               seg_cnt_d = seg_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         seg_cnt_q  <= '0;
         onehot_q   <= '0;
         var_idx_q  <= '0;
         done_q     <= 1'b0;
         all_q      <= 1'b0;
         next_lvl_q <= '1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         seg_cnt_q  <= seg_cnt_d;
         onehot_q   <= onehot_d;
         var_idx_q  <= var_idx_d;
         done_q     <= done_d;
         all_q      <= all_d;
         next_lvl_q <= next_lvl_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.index_decided_o = onehot_q;
   assign bus.var_idx_o       = var_idx_q;
   assign bus.decision_done   = done_q;
   assign bus.all_assigned_o  = all_q;
   assign bus.busy_o          = (state_q == SCAN);
   assign bus.cur_lvl_o       = next_lvl_q - 1'b1;
   assign bus.lvl_overflow_o  = ovf_q;
endmodule
